// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter sharing one I2C master config buffer and transaction engine
// among NREQ requesters, with a watchdog on each transaction.
module i2c_cfg_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   req_bus_address,
    input  logic [NREQ-1:0]      req_data_direction,
    input  logic [NREQ-1:0]      req_address_mode,
    input  logic [NREQ*32-1:0]   req_clock_div,
    input  logic [NREQ-1:0]      req_stretch_enabled,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 load_buffer,
    output logic [9:0]           u_bus_address,
    output logic                 u_data_direction,
    output logic                 u_address_mode,
    output logic [31:0]          u_clock_div,
    output logic                 u_stretch_enabled,
    output logic                 tx_start,
    output logic                 abort,
    input  logic                 master_busy,
    input  logic                 master_done,
    input  logic                 master_error
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   idx, ptr, win_idx;
    logic            win_valid;
    logic [WDW-1:0]  wdog;
    logic [NREQ-1:0] grant_d, done_d, err_d;
    logic            load_d, start_d, abort_d, capture, leave_run, wdog_clr;

    // Scan from the pointer upward with wrap; first set request wins.
    always_comb begin
        int cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state;
        grant_d   = '0;
        done_d    = '0;
        err_d     = '0;
        load_d    = 1'b0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        capture   = 1'b0;
        leave_run = 1'b0;
        wdog_clr  = 1'b0;
        case (state)
            IDLE: if (win_valid && !master_busy) begin
                capture = 1'b1;
                load_d  = 1'b1;
                grant_d = NREQ'(1) << win_idx;
                state_d = LOAD;
            end
            LOAD: begin
                start_d  = 1'b1;
                wdog_clr = 1'b1;
                state_d  = START;
            end
            START: state_d = RUN;
            RUN: begin
                // Error outranks done when both arrive in the same cycle.
                if (master_error) begin
                    err_d     = NREQ'(1) << idx;
                    leave_run = 1'b1;
                end else if (master_done) begin
                    done_d    = NREQ'(1) << idx;
                    leave_run = 1'b1;
                end else if (TIMEOUT != 0 && wdog >= WD_LAST) begin
                    abort_d   = 1'b1;
                    err_d     = NREQ'(1) << idx;
                    leave_run = 1'b1;
                end
                if (leave_run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            err         <= '0;
            load_buffer <= 1'b0;
            tx_start    <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            done        <= done_d;
            err         <= err_d;
            load_buffer <= load_d;
            tx_start    <= start_d;
            abort       <= abort_d;
        end
    end

    // Watchdog is zero during the tx_start cycle, so abort lands TIMEOUT cycles after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (wdog_clr) begin
            wdog <= '0;
        end else if (state == START || state == RUN) begin
            wdog <= wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx               <= '0;
            ptr               <= '0;
            u_bus_address     <= '0;
            u_data_direction  <= 1'b0;
            u_address_mode    <= 1'b0;
            u_clock_div       <= 32'd300;
            u_stretch_enabled <= 1'b1;
        end else begin
            if (capture) begin
                idx               <= win_idx;
                u_bus_address     <= req_bus_address[win_idx*10 +: 10];
                u_data_direction  <= req_data_direction[win_idx];
                u_address_mode    <= req_address_mode[win_idx];
                u_clock_div       <= req_clock_div[win_idx*32 +: 32];
                u_stretch_enabled <= req_stretch_enabled[win_idx];
            end
            if (leave_run) begin
                ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Directed bench for i2c_cfg_arbiter: reset, single request, round-robin,
// busy gating, watchdog, done/error collision and reset mid-transaction.
module tb_i2c_cfg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [19:0] req_bus_address;
    logic [1:0]  req_data_direction;
    logic [1:0]  req_address_mode;
    logic [63:0] req_clock_div;
    logic [1:0]  req_stretch_enabled;
    logic [1:0]  grant, done, err;
    logic        load_buffer;
    logic [9:0]  u_bus_address;
    logic        u_data_direction, u_address_mode, u_stretch_enabled;
    logic [31:0] u_clock_div;
    logic        tx_start, abort;
    logic        master_busy, master_done, master_error;

    int checks = 0;
    int errors = 0;

    i2c_cfg_arbiter #(.NREQ(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_bus_address(req_bus_address), .req_data_direction(req_data_direction),
        .req_address_mode(req_address_mode), .req_clock_div(req_clock_div),
        .req_stretch_enabled(req_stretch_enabled),
        .grant(grant), .done(done), .err(err), .load_buffer(load_buffer),
        .u_bus_address(u_bus_address), .u_data_direction(u_data_direction),
        .u_address_mode(u_address_mode), .u_clock_div(u_clock_div),
        .u_stretch_enabled(u_stretch_enabled), .tx_start(tx_start), .abort(abort),
        .master_busy(master_busy), .master_done(master_done), .master_error(master_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; master_busy = 1'b0; master_done = 1'b0; master_error = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_grant(input int max_cyc, output int cyc, output logic [1:0] g);
        cyc = 0;
        g   = '0;
        while (cyc < max_cyc) begin
            step();
            cyc++;
            if (grant != '0) begin
                g = grant;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; master_busy = 1'b0; master_done = 1'b0; master_error = 1'b0;
        step(); step();
        checks++;
        if ({grant, done, err, load_buffer, tx_start, abort} !== 9'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0", {grant, done, err, load_buffer, tx_start, abort});
        end
        checks++;
        if ({u_bus_address, u_data_direction, u_address_mode, u_clock_div, u_stretch_enabled} !==
            {10'h0, 1'b0, 1'b0, 32'd300, 1'b1}) begin
            errors++; $display("FAIL reset_cfg: got addr=%h dir=%b mode=%b div=%0d str=%b expected 0 0 0 300 1",
                               u_bus_address, u_data_direction, u_address_mode, u_clock_div, u_stretch_enabled);
        end
        rst = 1'b0;
        step();
        // With both requesting out of reset, requester 0 has priority.
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL reset_priority: got %b expected 01", grant); end
    endtask

    task automatic test_single();
        int cyc; logic [1:0] g;
        do_reset();
        req = 2'b01;
        wait_grant(1, cyc, g);
        checks++;
        if ({g, load_buffer} !== 3'b011) begin
            errors++; $display("FAIL single_grant: got grant=%b load=%b expected 01 1", g, load_buffer);
        end
        checks++;
        if ({u_bus_address, u_data_direction, u_address_mode, u_clock_div, u_stretch_enabled} !==
            {10'h02A, 1'b1, 1'b0, 32'd100, 1'b0}) begin
            errors++; $display("FAIL single_cfg: got addr=%h dir=%b mode=%b div=%0d str=%b expected 02a 1 0 100 0",
                               u_bus_address, u_data_direction, u_address_mode, u_clock_div, u_stretch_enabled);
        end
        req = 2'b00;
        step();
        checks++;
        if ({tx_start, load_buffer, grant} !== 4'b1000) begin
            errors++; $display("FAIL single_start: got tx=%b load=%b grant=%b expected 1 0 00", tx_start, load_buffer, grant);
        end
        step();
        master_done = 1'b1;
        step();
        master_done = 1'b0;
        checks++;
        if ({done, err} !== 4'b0100) begin errors++; $display("FAIL single_done: got done=%b err=%b expected 01 00", done, err); end
        step();
        checks++;
        if ({done, grant, u_bus_address} !== {4'b0000, 10'h02A}) begin
            errors++; $display("FAIL single_hold: got done=%b grant=%b addr=%h expected 00 00 02a", done, grant, u_bus_address);
        end
    endtask

    task automatic test_round_robin();
        int cyc; logic [1:0] g, prev, exp_g;
        do_reset();
        req  = 2'b11;
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(4, cyc, g);
            checks++;
            if (g !== exp_g || g === prev) begin
                errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, g, exp_g);
            end
            prev = g;
            step();
            repeat (5) step();
            master_done = 1'b1;
            step();
            master_done = 1'b0;
            checks++;
            if (done !== exp_g) begin errors++; $display("FAIL rr_done_%0d: got %b expected %b", k, done, exp_g); end
        end
        req = 2'b00;
    endtask

    task automatic test_busy();
        logic [1:0] seen;
        do_reset();
        master_busy = 1'b1;
        req  = 2'b01;
        seen = '0;
        repeat (20) begin
            step();
            seen = seen | grant;
        end
        checks++;
        if (seen !== 2'b00) begin errors++; $display("FAIL busy_hold: got grant=%b expected 00", seen); end
        master_busy = 1'b0;
        step();
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL busy_release: got %b expected 01", grant); end
        req = 2'b00;
    endtask

    task automatic test_watchdog();
        int cyc, c; logic [1:0] g;
        do_reset();
        req = 2'b10;
        wait_grant(2, cyc, g);
        req = 2'b00;
        step();
        checks++;
        if (tx_start !== 1'b1) begin errors++; $display("FAIL wd_start: got %b expected 1", tx_start); end
        c = 0;
        while (c < 40) begin
            step();
            c++;
            if (abort) break;
        end
        checks++;
        if (c != 16 || {abort, err, done} !== 5'b11000) begin
            errors++; $display("FAIL wd_abort: got cycles=%0d abort=%b err=%b done=%b expected 16 1 10 00", c, abort, err, done);
        end
        step();
        checks++;
        if ({abort, err} !== 3'b000) begin errors++; $display("FAIL wd_pulse: got abort=%b err=%b expected 0 00", abort, err); end
        req = 2'b11;
        step();
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL wd_idle: got %b expected 01", grant); end
        req = 2'b00;
    endtask

    task automatic test_done_err();
        int cyc; logic [1:0] g;
        do_reset();
        req = 2'b01;
        wait_grant(2, cyc, g);
        req = 2'b00;
        step(); step();
        master_done = 1'b1; master_error = 1'b1;
        step();
        master_done = 1'b0; master_error = 1'b0;
        checks++;
        if ({err, done} !== 4'b0100) begin errors++; $display("FAIL collide: got err=%b done=%b expected 01 00", err, done); end
        req = 2'b11;
        wait_grant(3, cyc, g);
        checks++;
        if (g !== 2'b10) begin errors++; $display("FAIL collide_ptr: got %b expected 10", g); end
        req = 2'b00;
    endtask

    task automatic test_rst_mid();
        int cyc; logic [1:0] g;
        do_reset();
        req = 2'b10;
        wait_grant(2, cyc, g);
        checks++;
        if (u_clock_div !== 32'd200) begin errors++; $display("FAIL mid_load: got %0d expected 200", u_clock_div); end
        req = 2'b00;
        step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({u_clock_div, u_stretch_enabled, u_bus_address, grant, done, err, load_buffer, tx_start, abort} !==
            {32'd300, 1'b1, 10'h0, 9'b0}) begin
            errors++; $display("FAIL mid_rst: got div=%0d str=%b addr=%h pulses=%b expected 300 1 000 0",
                               u_clock_div, u_stretch_enabled, u_bus_address, {grant, done, err, load_buffer, tx_start, abort});
        end
        step();
        rst = 1'b0;
        step();
        master_done = 1'b1;
        step();
        master_done = 1'b0;
        step();
        checks++;
        if ({done, err, load_buffer} !== 5'b0) begin
            errors++; $display("FAIL mid_ignore: got done=%b err=%b load=%b expected 00 00 0", done, err, load_buffer);
        end
    endtask

    initial begin
        req_bus_address     = {10'h3B5, 10'h02A};
        req_data_direction  = 2'b01;
        req_address_mode    = 2'b10;
        req_clock_div       = {32'd200, 32'd100};
        req_stretch_enabled = 2'b10;
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_watchdog();
        test_done_err();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
